// File: rtl/seg_share_arb_if.sv
// Bundle of requester-side and display-side signals for seg_share_arb.
//   req     : per-requester request, level-sensitive
//   data    : packed requester values, requester i at data[32*i +: 32]
//   gnt     : one-hot registered grant, zero when nobody owns the display
//   o_owner : index of the current owner, 0 when there is none
//   o_busy  : high while a requester owns the display
//   o_seg0..o_seg7 : active-low segments {a,b,c,d,e,f,g,dp}; o_seg0 is the
//                    least-significant hex digit
// master = requester/board side, slave = the arbiter.
interface seg_share_arb_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*32-1:0] data;
    logic [NREQ-1:0]    gnt;
    logic [2:0]         o_owner;
    logic               o_busy;
    logic [7:0]         o_seg0;
    logic [7:0]         o_seg1;
    logic [7:0]         o_seg2;
    logic [7:0]         o_seg3;
    logic [7:0]         o_seg4;
    logic [7:0]         o_seg5;
    logic [7:0]         o_seg6;
    logic [7:0]         o_seg7;

    modport master (
        output req, data,
        input  gnt, o_owner, o_busy,
        input  o_seg0, o_seg1, o_seg2, o_seg3, o_seg4, o_seg5, o_seg6, o_seg7
    );

    modport slave (
        input  req, data,
        output gnt, o_owner, o_busy,
        output o_seg0, o_seg1, o_seg2, o_seg3, o_seg4, o_seg5, o_seg6, o_seg7
    );
endinterface

// File: rtl/seg_share_arb.sv
// Round-robin arbiter sharing an eight-digit seven-segment bank between
// NREQ requesters. One owner at a time, a minimum dwell of DWELL cycles
// before a competing request may preempt, and a one-cycle blank GAP at
// every handover. All outputs are registered.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : seg_share_arb_if.slave (req/data in, gnt/owner/busy/segments out)
//
// state  | meaning
// -------+-----------------------------------------
// S_IDLE | no owner, display blank
// S_OWN  | one requester granted, display tracks its data
// S_GAP  | one-cycle blank handover between owners
module seg_share_arb #(
    parameter int NREQ  = 4,
    parameter int DWELL = 50000000
) (
    input logic           clk,
    input logic           rst,
    seg_share_arb_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_OWN, S_GAP} state_t;

    localparam int            CW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

    state_t        state, state_n;
    logic [2:0]    ptr, ptr_n;
    logic [2:0]    owner, owner_n;
    logic [CW-1:0] dwell_cnt, dwell_n;

    // Requests and data widened to eight slots so a 3-bit index is always legal.
    logic [7:0]  req8;
    logic [31:0] words [8];

    logic       pick_found;
    logic [2:0] pick_idx;
    logic [2:0] pick_next;
    logic [3:0] scan;
    logic [3:0] nxt;
    logic       others_req;
    logic       expired;

    logic [NREQ-1:0] gnt_n;
    logic [2:0]      o_owner_n;
    logic            busy_n;
    logic [31:0]     sel_word;
    logic [7:0]      seg_n [8];

    function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
        logic [7:0] hi;
        case (nib)
            4'h0: hi = 8'hFC;  4'h1: hi = 8'h60;  4'h2: hi = 8'hDA;  4'h3: hi = 8'hF2;
            4'h4: hi = 8'h66;  4'h5: hi = 8'hB6;  4'h6: hi = 8'hBE;  4'h7: hi = 8'hE0;
            4'h8: hi = 8'hFE;  4'h9: hi = 8'hE6;  4'hA: hi = 8'hEE;  4'hB: hi = 8'h3E;
            4'hC: hi = 8'h9C;  4'hD: hi = 8'h7A;  4'hE: hi = 8'h9E;  default: hi = 8'h8E;
        endcase
        return ~hi;
    endfunction

    assign req8 = 8'(bus.req);

    for (genvar gi = 0; gi < 8; gi++) begin : g_words
        if (gi < NREQ) begin : g_on
            assign words[gi] = bus.data[32*gi +: 32];
        end else begin : g_off
            assign words[gi] = '0;
        end
    end

    // Round-robin pick: scan from ptr upward with wrap. The loop runs from the
    // far end back toward ptr so the last hit written is the closest one.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan = {1'b0, ptr} + 4'(k);
            if (scan >= 4'(NREQ)) scan = scan - 4'(NREQ);
            if (req8[scan[2:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan[2:0];
            end
        end
        nxt       = {1'b0, pick_idx} + 4'd1;
        pick_next = (nxt == 4'(NREQ)) ? 3'd0 : nxt[2:0];
    end

    assign others_req = |(req8 & ~(8'd1 << owner));
    assign expired    = (dwell_cnt == DWELL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= '0;
            owner       <= '0;
            dwell_cnt   <= '0;
            bus.gnt     <= '0;
            bus.o_owner <= '0;
            bus.o_busy  <= 1'b0;
            bus.o_seg0  <= 8'hFF;
            bus.o_seg1  <= 8'hFF;
            bus.o_seg2  <= 8'hFF;
            bus.o_seg3  <= 8'hFF;
            bus.o_seg4  <= 8'hFF;
            bus.o_seg5  <= 8'hFF;
            bus.o_seg6  <= 8'hFF;
            bus.o_seg7  <= 8'hFF;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            owner       <= owner_n;
            dwell_cnt   <= dwell_n;
            bus.gnt     <= gnt_n;
            bus.o_owner <= o_owner_n;
            bus.o_busy  <= busy_n;
            bus.o_seg0  <= seg_n[0];
            bus.o_seg1  <= seg_n[1];
            bus.o_seg2  <= seg_n[2];
            bus.o_seg3  <= seg_n[3];
            bus.o_seg4  <= seg_n[4];
            bus.o_seg5  <= seg_n[5];
            bus.o_seg6  <= seg_n[6];
            bus.o_seg7  <= seg_n[7];
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        dwell_n = dwell_cnt;
        case (state)
            S_IDLE, S_GAP: begin
                if (pick_found) begin
                    state_n = S_OWN;
                    owner_n = pick_idx;
                    ptr_n   = pick_next;
                    dwell_n = '0;
                end else begin
                    state_n = S_IDLE;
                    owner_n = '0;
                end
            end
            S_OWN: begin
                // Owner release and expired preemption collapse into one GAP.
                if (!req8[owner] || (expired && others_req)) begin
                    state_n = S_GAP;
                    owner_n = '0;
                end else if (!expired) begin
                    dwell_n = dwell_cnt + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                owner_n = '0;
            end
        endcase
    end

    // Output values are computed from the next state so the registered
    // outputs line up with the state they describe.
    always_comb begin
        gnt_n     = '0;
        o_owner_n = '0;
        busy_n    = 1'b0;
        sel_word  = words[owner_n];
        for (int i = 0; i < 8; i++) seg_n[i] = 8'hFF;
        if (state_n == S_OWN) begin
            gnt_n     = NREQ'(8'd1 << owner_n);
            o_owner_n = owner_n;
            busy_n    = 1'b1;
            for (int i = 0; i < 8; i++) seg_n[i] = hex_glyph(sel_word[4*i +: 4]);
        end
    end
endmodule

// File: tb/tb_seg_share_arb.sv
module tb_seg_share_arb;
    localparam int NREQ  = 4;
    localparam int DWELL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_share_arb_if #(.NREQ(NREQ)) bus ();

    seg_share_arb #(.NREQ(NREQ), .DWELL(DWELL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic [2:0]      owner;
        logic            busy;
        logic [63:0]     segs;
    } obs_t;

    localparam logic [7:0] GLYPH_HI [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hE6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

    int n_checks = 0;
    int n_pass   = 0;
    obs_t exp_q [$];

    // Reference: owner (-1 = none), cycles already owned, round-robin pointer.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [63:0] show(input logic [31:0] w);
        logic [63:0] s;
        for (int n = 0; n < 8; n++) s[8*n +: 8] = ~GLYPH_HI[w[4*n +: 4]];
        return s;
    endfunction

    always @(posedge clk) begin
        obs_t e;
        int p;
        logic [NREQ-1:0] others;
        if (rst) begin
            m_owner = -1; m_held = 0; m_ptr = 0;
        end else if (m_owner >= 0) begin
            others = bus.req & ~(NREQ'(1) << m_owner);
            if (!bus.req[m_owner] || (m_held >= DWELL && others != '0)) begin
                m_owner = -1;   // handover gap: next pick happens one edge later
            end else begin
                m_held++;
            end
        end else begin
            p = rr_pick(bus.req, m_ptr);
            if (p >= 0) begin
                m_owner = p; m_held = 1; m_ptr = (p + 1) % NREQ;
            end
        end
        if (m_owner >= 0) begin
            e.gnt   = NREQ'(1) << m_owner;
            e.owner = 3'(m_owner);
            e.busy  = 1'b1;
            e.segs  = show(bus.data[32*m_owner +: 32]);
        end else begin
            e.gnt = '0; e.owner = '0; e.busy = 1'b0; e.segs = {8{8'hFF}};
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        obs_t a, e;
        a = '{bus.gnt, bus.o_owner, bus.o_busy,
              {bus.o_seg7, bus.o_seg6, bus.o_seg5, bus.o_seg4,
               bus.o_seg3, bus.o_seg2, bus.o_seg1, bus.o_seg0}};
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_empty at %0t: got %h", $time, a);
        end else begin
            e = exp_q.pop_front();
            if (a === e) n_pass++;
            else $display("FAIL scoreboard at %0t: got gnt=%b own=%0d busy=%b seg=%h, want gnt=%b own=%0d busy=%b seg=%h",
                          $time, a.gnt, a.owner, a.busy, a.segs, e.gnt, e.owner, e.busy, e.segs);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req  = '1;
        bus.data = '0;
        rst      = 1'b1;
        step(3);
        chk("reset_gnt",  64'(bus.gnt), 64'h0);
        chk("reset_busy", 64'(bus.o_busy), 64'h0);
        chk("reset_seg",  {bus.o_seg7, bus.o_seg6, bus.o_seg5, bus.o_seg4,
                           bus.o_seg3, bus.o_seg2, bus.o_seg1, bus.o_seg0}, {8{8'hFF}});
        rst = 1'b0;
        step(1);
        chk("first_grant", 64'(bus.gnt), 64'b0001);

        bus.req = 4'b0100;
        bus.data[64 +: 32] = 32'h89AB_CDEF;
        step(2);
        chk("hex_gnt",   64'(bus.gnt), 64'b0100);
        chk("hex_owner", 64'(bus.o_owner), 64'd2);
        chk("hex_seg0",  64'(bus.o_seg0), 64'(8'(~8'h8E)));
        chk("hex_seg7",  64'(bus.o_seg7), 64'(8'(~8'hFE)));
        step(100);
        chk("hold_gnt",  64'(bus.gnt), 64'b0100);

        bus.data[64 +: 32] = 32'h0;
        step(1);
        bus.data[64 +: 32] = 32'h5;
        step(1);
        chk("live_seg0", 64'(bus.o_seg0), 64'(8'(~8'hB6)));
        chk("live_seg1", 64'(bus.o_seg1), 64'(8'(~8'hFC)));

        bus.req = '0;
        step(2);
        chk("idle_busy", 64'(bus.o_busy), 64'h0);

        bus.req = 4'b1011;
        step(30);

        bus.req = '0;
        step(2);
        bus.req = 4'b0010;
        step(1);
        chk("early_gnt1", 64'(bus.gnt), 64'b0010);
        bus.req = 4'b1010;
        step(1);
        bus.req = 4'b1000;
        step(1);
        chk("early_gap", 64'(bus.gnt), 64'h0);
        step(1);
        chk("early_gnt3", 64'(bus.gnt), 64'b1000);

        bus.req = '0;
        step(2);
        bus.req = 4'b0100;
        step(2);
        chk("mid_gnt2", 64'(bus.gnt), 64'b0100);
        rst = 1'b1;
        bus.req = 4'b0110;
        step(1);
        chk("mid_rst_gnt",   64'(bus.gnt), 64'h0);
        chk("mid_rst_owner", 64'(bus.o_owner), 64'h0);
        rst = 1'b0;
        step(1);
        chk("mid_rst_next", 64'(bus.gnt), 64'b0010);

        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(7) == 0) bus.req = NREQ'($urandom);
            if ($urandom_range(1) == 0) bus.data[32*$urandom_range(NREQ-1) +: 32] = $urandom;
            rst = ($urandom_range(199) == 0);
            step(1);
        end
        rst = 1'b0;
        bus.req = '0;
        step(3);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/seg_share_arb.md
# seg_share_arb

Round-robin arbiter that shares the eight-digit seven-segment display bank between several requesters, such as the ALU result path, counters and keyboard scan codes. Each requester presents a 32-bit value to be shown as eight hex digits and requests ownership. The arbiter grants one owner at a time and enforces a minimum dwell time before rotating. It blanks the bank for one cycle between owners and drives the registered active-low segment outputs directly to the board.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..8.
- `DWELL`, default 50000000: minimum cycles an owner keeps the display before it can be preempted; must be ≥1.
- `clk` in, 1: system clock; all logic is on the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `req` in, NREQ: per-requester request, level-sensitive.
- `data` in, NREQ*32: requester i's value is `data[32*i+31:32*i]`.
- `gnt` out, NREQ: one-hot grant, registered; all zero when there is no owner.
- `o_owner` out, 3: index of the current owner; 0 when there is no owner.
- `o_busy` out, 1: high while a requester owns the display.
- `o_seg0`..`o_seg7` out, 8 each: active-low segments; bit7=a … bit1=g, bit0=dp. A 1 turns the segment off.

## Operation
- States:
  - IDLE: no owner, display blank.
  - OWN: a requester is granted.
  - GAP: one-cycle blank handover.
- Digit mapping: `o_segN` shows nibble `data[owner][4N+3:4N]`, so `o_seg0` is the least-significant nibble. The decimal point is always off (bit0=1).
- Hex glyphs are the active-high pattern inverted. Active-high patterns:
  - 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=E6
  - A=EE, b=3E, C=9C, d=7A, E=9E, F=8E
- Blank = 8'hFF on all eight digits.
- Round-robin pointer `ptr`:
  - After requester i is granted, `ptr` = (i+1) mod NREQ.
  - Arbitration picks the first asserted `req` scanning `ptr`, ptr+1, … with wrap-around.
- IDLE → OWN: taken when any `req` is high, using the round-robin pick.
- OWN behaviour:
  - The dwell counter clears on entry, increments each cycle, and saturates at DWELL-1. "Expired" means the count equals DWELL-1.
  - Owner's `req` low → GAP, regardless of dwell.
  - Expired and some other `req` high → GAP. This is preemption.
  - Otherwise stay in OWN. A sole requester holds the display indefinitely.
  - While in OWN, the display live-tracks the owner's `data` every cycle.
- GAP:
  - Always lasts exactly one cycle, with `gnt`=0 and display blank.
  - On exit, arbitrate over the current `req`: a pick → OWN, none → IDLE.
  - A requester that was just preempted but still requests is only re-granted if no other request is pending, because `ptr` has moved past it.
- Simultaneous events:
  - If the owner drops `req` in the same cycle that dwell expires with others pending, the arbiter takes a single GAP.
  - Requests that arrive in IDLE during the same cycle are resolved by `ptr` order.
- Reset values:
  - state=IDLE, `ptr`=0, dwell counter=0.
  - `gnt`=0, `o_owner`=0, `o_busy`=0.
  - `o_seg0`..`o_seg7`=8'hFF.

## Timing
- All outputs are registered. There are no combinational paths from `req` or `data` to any output.
- Grant latency: `req` high at edge t while in IDLE → `gnt`, `o_owner` and `o_busy` valid after edge t+1.
- Display latency: the display shows `data` sampled at the edge where `gnt` rises. After that it follows `data` with one cycle of latency.
- Release: owner `req` low at edge t → `gnt`=0 and display blank after edge t+1 (GAP). The next owner's `gnt` and display are valid after edge t+2.
- Preemption: with DWELL=D and a competing request present, the owner is granted for exactly D cycles, followed by one GAP cycle.
- Reset mid-operation: `rst` high at any edge forces all reset values after that edge, regardless of state. No grant is issued on the reset edge.
- `data` of non-owners is ignored. `req` is sampled only at clock edges; there is no glitch filtering.

## Test plan
- **Reset:** hold `rst` 3 cycles while `req`=4'b1111 → `gnt`=0, `o_busy`=0, all `o_seg`=8'hFF; first grant goes to req0 one cycle after `rst` falls.
- **Single owner, hex decode** (NREQ=4, DWELL=4): `req`=4'b0100, `data[2]`=32'h89AB_CDEF → `gnt`=4'b0100, `o_owner`=2; `o_seg0`=~8E (F) … `o_seg7`=~FE (8). Owner held for 100 cycles with no GAP.
- **Live update:** while owner, change `data` from 32'h0000_0000 to 32'h0000_0005 → after one edge `o_seg0`=~B6, and `o_seg1`..`o_seg7`=~FC.
- **Rotation** (DWELL=4): `req`=4'b1011 held constant → owner sequence 0,1,3,0; each owner granted exactly 4 cycles, separated by one GAP cycle with `gnt`=0 and blank display.
- **Early release:** owner 1 drops `req` after 2 cycles while req3 is pending → one GAP cycle, then `gnt`=4'b1000. If no request is pending → IDLE, `o_busy`=0, display blank.
- **Reset mid-grant:** assert `rst` during OWN of requester 2 → after the edge all reset values; `ptr`=0, so with `req`=4'b0110 the next grant goes to requester 1.
